// File: rtl/fe_frame_arbiter.sv
// -----------------------------------------------------------------------------
// fe_frame_arbiter
//
// Purpose
//   Shares a single Fe frame-sender between NREQ requesters. A round-robin
//   arbiter picks one owner, drives the sender's Fe input (fe_start), counts
//   one fe_ack rising edge per bit up to BITS_PER_FRAME, waits for a
//   fe_senack rising edge, pulses done to the owner and releases the sender.
//
// Parameters
//   NREQ            number of requesters (2..8)
//   BITS_PER_FRAME  fe_ack rising edges per frame (1..15)
//   TIMEOUT         cycles allowed between handshake events (watchdog build)
//
// Ports
//   clk        in   1     single clock, rising edge
//   reset      in   1     synchronous, active-high
//   req        in   NREQ  level request per client
//   gnt        out  NREQ  one-hot owner of the Fe unit, 0 when idle
//   done       out  NREQ  one-cycle pulse to the owner at frame end
//   fe_start   out  1     Fe input of the sender
//   fe_ack     in   1     per-bit ack from the sender (rising edge counts)
//   fe_senack  in   1     frame-complete from the sender (rising edge counts)
//   bit_cnt    out  4     ack edges counted in the current frame
//   busy       out  1     high in every state except IDLE
//   err        out  1     sticky watchdog flag (constant 0 without watchdog)
//   state_dbg  out  3     current FSM state (0 IDLE, 1 GRANT, 2 SEND,
//                         3 WAIT_SEN, 4 DONE)
//
// Build option
//   FE_ARB_TIMEOUT_EN  adds a watchdog that aborts a stalled frame, sets err
//                      and releases the sender without a done pulse.
//
// Client handshake
//   A client raises req and holds it until it sees its done bit. gnt shows
//   the current owner from the cycle after the request is taken until the
//   DONE cycle; done[owner] is high for exactly that one DONE cycle. Dropping
//   req while owning the sender does not abort the frame.
// -----------------------------------------------------------------------------
module fe_frame_arbiter #(
  parameter int NREQ           = 4,
  parameter int BITS_PER_FRAME = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            fe_start,
  input  logic            fe_ack,
  input  logic            fe_senack,
  output logic [3:0]      bit_cnt,
  output logic            busy,
  output logic            err,
  output logic [2:0]      state_dbg
);

  localparam int          PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]  BPF = 4'(BITS_PER_FRAME);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GRANT    = 3'd1,
    S_SEND     = 3'd2,
    S_WAIT_SEN = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [PW-1:0]     rr, rr_n;
  logic [PW-1:0]     owner, owner_n;
  logic [PW-1:0]     owner_inc;
  logic [NREQ-1:0]   gnt_n, done_n;
  logic [NREQ-1:0]   owner_hot;
  logic              fe_start_n;
  logic [3:0]        bit_cnt_n;
  logic [3:0]        bit_cnt_inc;
  logic              err_n;

  logic              ack_q, sen_q;
  logic              ack_rise, sen_rise;
  logic              timeout_hit;

  logic [NREQ-1:0]   req_rot;
  logic [PW:0]       win_sum;
  logic [PW-1:0]     win;
  logic              win_vld;

  // ---------------------------------------------------------------------------
  // Edge detection on the sender's handshake lines (runs in every state)
  // ---------------------------------------------------------------------------
  assign ack_rise = fe_ack & ~ack_q;
  assign sen_rise = fe_senack & ~sen_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q <= 1'b0;
      sen_q <= 1'b0;
    end else begin
      ack_q <= fe_ack;
      sen_q <= fe_senack;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: rotate req so the rr pointer sits at bit 0, take the
  // lowest set bit, then rotate the index back (mod NREQ).
  // ---------------------------------------------------------------------------
  assign req_rot = NREQ'({req, req} >> rr);

  always_comb begin
    win_vld = 1'b0;
    win_sum = '0;
    win     = '0;
    // Descending scan so the lowest set bit is the one left standing.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_vld = 1'b1;
        win_sum = {1'b0, rr} + (PW+1)'(i);
      end
    end
    if (win_sum >= (PW+1)'(NREQ)) begin
      win = PW'(win_sum - (PW+1)'(NREQ));
    end else begin
      win = PW'(win_sum);
    end
  end

  assign owner_inc   = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign owner_hot   = {{(NREQ-1){1'b0}}, 1'b1} << owner;
  assign bit_cnt_inc = bit_cnt + 4'd1;

  // ---------------------------------------------------------------------------
  // Optional watchdog
  // ---------------------------------------------------------------------------
`ifdef FE_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  logic [15:0] wd_cnt;

  // Cleared whenever the FSM changes state or the sender shows progress;
  // saturates so a long IDLE period cannot wrap it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if ((state_n != state) || ack_rise || sen_rise) begin
      wd_cnt <= '0;
    end else if (wd_cnt != 16'hffff) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  assign timeout_hit = ((state == S_SEND) || (state == S_WAIT_SEN)) &&
                       (wd_cnt >= TO_LIMIT) && !ack_rise && !sen_rise;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      rr       <= '0;
      owner    <= '0;
      gnt      <= '0;
      done     <= '0;
      fe_start <= 1'b0;
      bit_cnt  <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      rr       <= rr_n;
      owner    <= owner_n;
      gnt      <= gnt_n;
      done     <= done_n;
      fe_start <= fe_start_n;
      bit_cnt  <= bit_cnt_n;
      err      <= err_n;
    end
  end

  // Outputs are computed for the state being entered, so gnt/fe_start/done
  // line up with the state they belong to without extra decode.
  always_comb begin
    state_n    = state;
    rr_n       = rr;
    owner_n    = owner;
    gnt_n      = gnt;
    done_n     = '0;
    fe_start_n = fe_start;
    bit_cnt_n  = bit_cnt;
    err_n      = err;

    case (state)
      S_IDLE: begin
        if (win_vld) begin
          state_n = S_GRANT;
          owner_n = win;
          gnt_n   = {{(NREQ-1){1'b0}}, 1'b1} << win;
        end
      end

      S_GRANT: begin
        state_n    = S_SEND;
        fe_start_n = 1'b1;
        bit_cnt_n  = '0;
      end

      S_SEND: begin
        if (timeout_hit) begin
          state_n    = S_DONE;
          fe_start_n = 1'b0;
          gnt_n      = '0;
          rr_n       = owner_inc;
          err_n      = 1'b1;
        end else if (ack_rise) begin
          // sen_rise is deliberately not looked at here.
          bit_cnt_n = bit_cnt_inc;
          if (bit_cnt_inc == BPF) begin
            state_n = S_WAIT_SEN;
          end
        end
      end

      S_WAIT_SEN: begin
        // Further ack edges are ignored; bit_cnt stays at its final value.
        if (timeout_hit) begin
          state_n    = S_DONE;
          fe_start_n = 1'b0;
          gnt_n      = '0;
          rr_n       = owner_inc;
          err_n      = 1'b1;
        end else if (sen_rise) begin
          state_n    = S_DONE;
          done_n     = owner_hot;
          fe_start_n = 1'b0;
          gnt_n      = '0;
          rr_n       = owner_inc;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n    = S_IDLE;
        gnt_n      = '0;
        fe_start_n = 1'b0;
      end
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule
